// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave front end
// Purpose: FSM state encoding, word widths and command codes used by
//          spi_slave_if and spi_tx_shifter.
// Ports:   none (package).
package spi_pkg;

    localparam int RX_W = 10;
    localparam int TX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA
    } state_t;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - parallel-in serial-out byte shifter driving miso
// Purpose: loads a byte, then presents it MSB first, one bit per clock, on a
//          registered output; the output is 0 whenever no bit is being sent.
// Ports:   clk, rst      - clock, asynchronous active-high reset
//          load, data    - capture data (takes effect on this edge)
//          abort         - drop any remaining bits, force the output low
//          bit_out       - registered serial output
//          done          - one-cycle flag, high in the cycle bit 0 is driven
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         abort,
    input  logic [W-1:0] data,
    output logic         bit_out,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] left_q, left_d;
    logic          bit_q, bit_d;
    logic          done_q, done_d;

    always_comb begin
        sh_d   = sh_q;
        left_d = left_q;
        bit_d  = 1'b0;
        done_d = 1'b0;
        if (abort) begin
            left_d = '0;
        end else if (load) begin
            sh_d   = data;
            left_d = CW'(W);
        end else if (left_q != '0) begin
            bit_d  = sh_q[W-1];
            sh_d   = {sh_q[W-2:0], 1'b0};
            left_d = left_q - 1'b1;
            done_d = (left_q == CW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            left_q <= '0;
            bit_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            left_q <= left_d;
            bit_q  <= bit_d;
            done_q <= done_d;
        end
    end

    assign bit_out = bit_q;
    assign done    = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end for the SPI RAM
// Purpose: deserialises 10-bit MOSI frames {cmd, payload}, strobes rx_valid,
//          and for read-data frames serialises the RAM's byte onto miso.
// Ports:   clk (also SCK), rst (async, active high), ss_n, mosi, miso,
//          rx_data/rx_valid (received word), tx_data/tx_valid (RAM byte).
module spi_slave_if #(
    parameter int RX_W = spi_pkg::RX_W,
    parameter int TX_W = spi_pkg::TX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    import spi_pkg::*;

    // Counter runs 1..RX_W while receiving, holds RX_W while waiting for the
    // RAM, and parks at RX_W+1 once the byte is loaded, so it never wraps.
    localparam int CNT_W = $clog2(RX_W + TX_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(RX_W);
    localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(RX_W + 1);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RX_W-2:0] rx_shift_q, rx_shift_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rd_addr_done_q, rd_addr_done_d;
    logic            tx_load, tx_abort, tx_done;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_load        = 1'b0;
        tx_abort       = 1'b0;

        // Bit 0 of the read byte has gone out, so the address is consumed.
        if (tx_done) begin
            rd_addr_done_d = 1'b0;
        end

        if (ss_n) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            tx_abort = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHK_CMD;
                    cnt_d   = '0;
                end
                ST_CHK_CMD: begin
                    rx_shift_d = {rx_shift_q[RX_W-3:0], mosi};
                    cnt_d      = CNT_W'(1);
                    if (!mosi) begin
                        state_d = ST_WRITE;
                    end else if (rd_addr_done_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                default: begin
                    if (cnt_q < CNT_WAIT) begin
                        rx_shift_d = {rx_shift_q[RX_W-3:0], mosi};
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = {rx_shift_q, mosi};
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD) begin
                                rd_addr_done_d = 1'b1;
                            end
                        end
                    end else if (state_q == ST_READ_DATA && cnt_q == CNT_WAIT
                                 && tx_valid) begin
                        // Only tx_valid seen after rx_valid gets here, so a
                        // level left over from an earlier read is ignored.
                        tx_load = 1'b1;
                        cnt_d   = CNT_SHIFT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
        end
    end

    spi_tx_shifter #(.W(TX_W)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (tx_load),
        .abort   (tx_abort),
        .data    (tx_data),
        .bit_out (miso),
        .done    (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - self-checking bench for spi_slave_if
module tb_spi_slave_if;

    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ss_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso, rx_valid;
    logic [9:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_if dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    int         errors = 0;
    int         checks = 0;
    bit         model_done;     // reference: a read address is pending
    int         v_cnt;
    bit         v_last;
    logic [9:0] got_word;
    bit         miso_seen;
    logic       miso_arr [0:15];
    int         extra_v;
    bit         pre_miso;

    // 0 = write, 1 = read address, 2 = read data
    function automatic int route(input logic [9:0] w);
        if (w[9:8] == WR_ADDR || w[9:8] == WR_DATA) return 0;
        return model_done ? 2 : 1;
    endfunction

    function automatic logic [7:0] stream_byte();
        logic [7:0] r;
        for (int j = 1; j <= 8; j++) r[8-j] = miso_arr[j];
        return r;
    endfunction

    function automatic bit stream_quiet();
        return miso_arr[0] === 1'b0 && miso_arr[9] === 1'b0 && miso_arr[10] === 1'b0;
    endfunction

    function automatic bit all_zero(input int n);
        for (int j = 0; j < n; j++) if (miso_arr[j] !== 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    // Select, one setup clock, then 10 bits MSB first; ends on the negedge
    // where rx_valid for bit 0 should be visible.
    task automatic drive_frame(input logic [9:0] w);
        v_cnt = 0; v_last = 1'b0; miso_seen = 1'b0; got_word = '0;
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            if (rx_valid) begin v_cnt++; got_word = rx_data; end
            if (miso !== 1'b0) miso_seen = 1'b1;
            mosi = w[i];
        end
        @(negedge clk);
        v_last = rx_valid;
        if (rx_valid) begin v_cnt++; got_word = rx_data; end
        if (miso !== 1'b0) miso_seen = 1'b1;
    endtask

    // Present a byte after 'delay' idle clocks and record n miso samples;
    // sample 0 reflects the edge that sees tx_valid first.
    task automatic feed_tx(input logic [7:0] b, input int delay, input int n);
        extra_v = 0; pre_miso = 1'b0;
        tx_data = b;
        if (delay > 0) begin
            tx_valid = 1'b0;
            repeat (delay) begin
                @(negedge clk);
                if (rx_valid) extra_v++;
                if (miso !== 1'b0) pre_miso = 1'b1;
            end
        end
        tx_valid = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            miso_arr[j] = miso;
            if (rx_valid) extra_v++;
        end
        tx_valid = 1'b0;
    endtask

    task automatic end_frame();
        ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
        model_done = 1'b0;
        @(negedge clk);
        checks++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_state: miso=%b rx_valid=%b rx_data=%h, expected 0/0/000", miso, rx_valid, rx_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [9:0] words [2];
        words[0] = 10'b00_0101_0101;
        words[1] = 10'b01_1010_1010;
        for (int k = 0; k < 2; k++) begin
            drive_frame(words[k]);
            feed_tx(8'hFF, 0, 11);
            checks++;
            if (v_cnt !== 1 || v_last !== 1'b1 || extra_v !== 0) begin
                errors++;
                $display("FAIL write_valid[%0d]: pulses=%0d on_10th=%b later=%0d, expected 1/1/0", k, v_cnt, v_last, extra_v);
            end
            checks++;
            if (got_word !== words[k]) begin
                errors++;
                $display("FAIL write_data[%0d]: got %h expected %h", k, got_word, words[k]);
            end
            checks++;
            if (!all_zero(11) || miso_seen) begin
                errors++;
                $display("FAIL write_miso[%0d]: miso active on a write frame, expected quiet", k);
            end
            end_frame();
        end
    endtask

    task automatic test_read();
        drive_frame(10'b10_0000_0011);
        checks++;
        if (v_cnt !== 1 || got_word !== 10'h203) begin
            errors++;
            $display("FAIL rd_addr: pulses=%0d data=%h, expected 1 pulse with 203", v_cnt, got_word);
        end
        model_done = 1'b1;
        end_frame();

        drive_frame(10'h3A5);
        checks++;
        if (v_cnt !== 1 || got_word !== 10'h3A5 || miso_seen) begin
            errors++;
            $display("FAIL rd_data_rx: pulses=%0d data=%h miso_seen=%b, expected 1/3A5/0", v_cnt, got_word, miso_seen);
        end
        feed_tx(8'hC3, 0, 11);
        checks++;
        if (stream_byte() !== 8'hC3 || !stream_quiet() || extra_v !== 0) begin
            errors++;
            $display("FAIL rd_data_stream: byte=%h quiet=%b extra_valid=%0d, expected C3/1/0", stream_byte(), stream_quiet(), extra_v);
        end
        model_done = 1'b0;
        end_frame();

        // Address is consumed: the next read frame must be treated as an address.
        drive_frame(10'h37E);
        feed_tx(8'hFF, 0, 11);
        checks++;
        if (route(10'h37E) !== 1 || v_cnt !== 1 || got_word !== 10'h37E || !all_zero(11)) begin
            errors++;
            $display("FAIL rd_done_cleared: data=%h miso_active=%b, expected 37E and no miso", got_word, !all_zero(11));
        end
        model_done = 1'b1;
        end_frame();
    endtask

    task automatic test_stale_tx_valid();
        tx_valid = 1'b1; tx_data = 8'h5A;
        drive_frame(10'h3C1);
        checks++;
        if (miso_seen || v_cnt !== 1 || got_word !== 10'h3C1) begin
            errors++;
            $display("FAIL stale_rx: miso_seen=%b pulses=%0d data=%h, expected 0/1/3C1", miso_seen, v_cnt, got_word);
        end
        feed_tx(8'hC3, 0, 11);
        checks++;
        if (stream_byte() !== 8'hC3 || !stream_quiet()) begin
            errors++;
            $display("FAIL stale_stream: byte=%h quiet=%b, expected C3/1", stream_byte(), stream_quiet());
        end
        model_done = 1'b0;
        end_frame();
    endtask

    task automatic test_abort();
        int n_valid;
        drive_frame(10'h211);
        model_done = 1'b1;
        end_frame();

        n_valid = 0;
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rx_valid) n_valid++;
            mosi = 1'($urandom_range(0, 1)) & (i != 0);
        end
        @(negedge clk); ss_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rx_valid) n_valid++;
        end
        checks++;
        if (n_valid !== 0) begin
            errors++;
            $display("FAIL abort_write: rx_valid pulses=%0d, expected 0", n_valid);
        end

        // Address survives the aborted write; abort a read mid-byte.
        drive_frame(10'h3C0);
        feed_tx(8'hE0, 1, 4);
        checks++;
        if (miso_arr[0] !== 1'b0 || miso_arr[1] !== 1'b1 || miso_arr[2] !== 1'b1 || miso_arr[3] !== 1'b1 || pre_miso) begin
            errors++;
            $display("FAIL abort_partial: bits=%b%b%b%b, expected 0111", miso_arr[0], miso_arr[1], miso_arr[2], miso_arr[3]);
        end
        ss_n = 1'b1;
        @(negedge clk);
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL abort_miso: miso=%b, expected 0", miso);
        end
        @(negedge clk);

        drive_frame(10'h30F);
        feed_tx(8'h96, 2, 11);
        checks++;
        if (route(10'h30F) !== 2 || stream_byte() !== 8'h96 || !stream_quiet() || pre_miso) begin
            errors++;
            $display("FAIL abort_keeps_addr: byte=%h quiet=%b, expected 96/1", stream_byte(), stream_quiet());
        end
        model_done = 1'b0;
        end_frame();
    endtask

    task automatic test_rd_no_addr();
        drive_frame(10'h3B7);
        feed_tx(8'hA5, 0, 11);
        checks++;
        if (v_cnt !== 1 || got_word !== 10'h3B7 || !all_zero(11) || miso_seen) begin
            errors++;
            $display("FAIL rd_no_addr: pulses=%0d data=%h miso_active=%b, expected 1/3B7/0", v_cnt, got_word, !all_zero(11));
        end
        model_done = 1'b1;
        end_frame();
    endtask

    task automatic test_reset_mid();
        drive_frame(10'h3A5);
        feed_tx(8'hFF, 0, 3);
        tx_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_stream: miso=%b rx_valid=%b rx_data=%h, expected 0/0/000", miso, rx_valid, rx_data);
        end
        model_done = 1'b0;
        ss_n = 1'b1; tx_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Reset after 5 bits of a frame.
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); mosi = 1'b1; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (miso !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: miso=%b rx_valid=%b, expected 0/0", miso, rx_valid);
        end
        ss_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        drive_frame(10'h2F0);
        feed_tx(8'hFF, 0, 11);
        checks++;
        if (route(10'h2F0) !== 1 || v_cnt !== 1 || v_last !== 1'b1 || got_word !== 10'h2F0 || !all_zero(11)) begin
            errors++;
            $display("FAIL reset_next_frame: pulses=%0d data=%h miso_active=%b, expected 1/2F0/0", v_cnt, got_word, !all_zero(11));
        end
        model_done = 1'b1;
        end_frame();
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            logic [9:0] w;
            logic [7:0] b;
            int d, r;
            w = 10'($urandom_range(0, 1023));
            b = 8'($urandom);
            d = $urandom_range(0, 3);
            r = route(w);
            drive_frame(w);
            checks++;
            if (v_cnt !== 1 || v_last !== 1'b1 || got_word !== w || miso_seen) begin
                errors++;
                $display("FAIL rand_rx[%0d]: pulses=%0d data=%h, expected 1 pulse with %h", k, v_cnt, got_word, w);
            end
            feed_tx(b, d, 11);
            checks++;
            if (r == 2) begin
                if (stream_byte() !== b || !stream_quiet() || pre_miso || extra_v !== 0) begin
                    errors++;
                    $display("FAIL rand_stream[%0d]: byte=%h quiet=%b, expected %h/1", k, stream_byte(), stream_quiet(), b);
                end
                model_done = 1'b0;
            end else begin
                if (!all_zero(11) || pre_miso || extra_v !== 0) begin
                    errors++;
                    $display("FAIL rand_quiet[%0d]: miso active on route %0d word %h, expected quiet", k, r, w);
                end
                if (r == 1) model_done = 1'b1;
            end
            end_frame();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stale_tx_valid();
        test_abort();
        test_rd_no_addr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end sitting directly upstream of the SPI RAM, on the same system clock (clk doubles as SCK).
- Deserialises MOSI frames into 10-bit words {cmd[1:0], payload[7:0]} and presents them with a one-cycle rx_valid pulse.
- For read-data frames, it waits for the RAM's tx_valid/tx_data and serialises the byte onto MISO, MSB first.

Parameters:
- RX_W, 10, width of a received word (2 command bits + 8 payload bits).
- TX_W, 8, width of a transmitted byte.

Ports:
- clk  in  1  system clock; also the SPI bit clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ss_n  in  1  slave select, active low; high ends or aborts a frame.
- mosi  in  1  serial data in, sampled on rising clk while ss_n=0.
- miso  out  1  serial data out, registered.
- rx_data  out  RX_W  assembled word, MSB = first bit received.
- rx_valid  out  1  one-cycle strobe: rx_data is valid.
- tx_data  in  TX_W  read byte from the RAM.
- tx_valid  in  1  the RAM has tx_data ready; may stay high for many cycles.

Behaviour:
- Reset: state=IDLE, miso=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_done=0, tx shift register=0. Reset takes effect immediately, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE: ss_n=0 -> CHK_CMD; otherwise stay.
  - CHK_CMD: the mosi sampled this cycle is rx bit 9.
    - mosi=0 -> WRITE.
    - mosi=1 and rd_addr_done=0 -> READ_ADD.
    - mosi=1 and rd_addr_done=1 -> READ_DATA.
  - ss_n=1 in any non-IDLE state -> IDLE on the next edge.
    - Counter is cleared and no rx_valid is issued.
    - rd_addr_done keeps its value.
- Receive, common to WRITE, READ_ADD and READ_DATA:
  - Shift in mosi for bits 8 down to 0 (9 cycles after CHK_CMD).
  - On the edge that captures bit 0, rx_data is updated and rx_valid=1 for exactly one cycle.
  - Latency from the first bit sampled to the rx_valid high cycle is 10 clks.
  - Further mosi bits in the same frame are ignored; only ss_n=1 ends the frame.
- WRITE: nothing further after rx_valid.
- READ_ADD: set rd_addr_done=1 in the same cycle as rx_valid.
- READ_DATA:
  - After rx_valid, enter the wait sub-phase.
  - The first cycle with tx_valid=1 after rx_valid loads tx_data into the shift register.
  - tx_valid levels seen before rx_valid are ignored, since the RAM's tx_valid can stay high from a previous read.
  - On the next 8 edges miso = tx_data[7], tx_data[6], ..., tx_data[0]; each bit is held one clk.
  - After bit 0, miso=0 and rd_addr_done clears.
  - Abort by ss_n=1 before bit 0 is sent: rd_addr_done remains set.
- miso=0 whenever the block is not shifting.
- tx_valid outside the READ_DATA wait sub-phase is ignored.
- Counter width: ceil(log2(RX_W+TX_W)) bits; it must not wrap within a frame.

Decomposition:
- Shared package spi_pkg holds:
  - state enumeration (5 states);
  - RX_W/TX_W constants;
  - command codes: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
- One natural sub-module: spi_tx_shifter (load/shift 8-bit PISO with done flag). The FSM and receive shifter stay in the top module.

Test Plan:
- Reset mid-frame: assert rst after 5 bits -> miso=0 and rx_valid=0 immediately; next frame decodes correctly from CHK_CMD.
- Write frame: ss_n=0, send 10'b00_0101_0101 -> after 10 clks rx_data=10'h055 and rx_valid=1 for exactly one cycle; then send 10'b01_1010_1010 -> rx_data=10'h1AA.
- Read address then read data:
  - Frame 10'b10_0000_0011 -> rx_valid with 10'h203, and rd_addr_done=1.
  - Next frame starting with 1 routes to READ_DATA -> rx_valid with 10'h3xx.
  - Drive tx_valid=1, tx_data=8'hC3 -> miso streams 1,1,0,0,0,0,1,1 on 8 consecutive edges, then 0; rd_addr_done=0.
- Stale tx_valid: hold tx_valid=1 throughout a READ_DATA frame -> no shift starts before rx_valid; the byte loads on the first tx_valid cycle after rx_valid.
- Abort: raise ss_n after 6 bits of a write -> IDLE next edge, no rx_valid; rd_addr_done unchanged.
- Read-data without a prior address: with rd_addr_done=0, send frame 10'b11_xxxx_xxxx -> routed to READ_ADD, rx_valid with 10'h3xx, no miso activity.
